// File: rtl/sdpb_pkg.sv
// Shared helpers for the simple-dual-port block RAM model: width ratios,
// power-of-two checks and storage sizing.
package sdpb_pkg;

    typedef enum logic {
        RD_BYPASS   = 1'b0,
        RD_PIPELINE = 1'b1
    } read_mode_e;

    // Storage size of the default 8x32 / 16x16 configuration.
    localparam int DEFAULT_STORAGE_BITS = 256;

    function automatic int ratio(int a, int b);
        return (a >= b) ? a / b : b / a;
    endfunction

    function automatic bit is_pow2(int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic int storage_bits(int depth, int width);
        return depth * width;
    endfunction

endpackage

// File: rtl/sdpb_out_reg.sv
// Enable/reset data register used for the read and pipeline output stages.
module sdpb_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sdpb_sim.sv
// Simple-dual-port RAM with independent write (A) and read (B) widths,
// stored as an array of narrow lanes so either side can be the wide one.
module sdpb_sim
    import sdpb_pkg::*;
#(
    parameter int ADDRESS_DEPTH_A = 8,
    parameter int DATA_WIDTH_A    = 32,
    parameter int ADDRESS_DEPTH_B = 16,
    parameter int DATA_WIDTH_B    = 16,
    parameter int READ_MODE       = 0
) (
    input  logic                               clka,
    input  logic                               reseta,
    input  logic                               cea,
    input  logic [$clog2(ADDRESS_DEPTH_A)-1:0] ada,
    input  logic [DATA_WIDTH_A-1:0]            din,
    input  logic                               ceb,
    input  logic                               oce,
    input  logic [$clog2(ADDRESS_DEPTH_B)-1:0] adb,
    output logic [DATA_WIDTH_B-1:0]            dout
);

    localparam int STORAGE_BITS = storage_bits(ADDRESS_DEPTH_A, DATA_WIDTH_A);
    localparam int LANE_W       = (DATA_WIDTH_A < DATA_WIDTH_B) ? DATA_WIDTH_A : DATA_WIDTH_B;
    localparam int WIDE_W       = (DATA_WIDTH_A < DATA_WIDTH_B) ? DATA_WIDTH_B : DATA_WIDTH_A;
    localparam int LANE_DEPTH   = STORAGE_BITS / LANE_W;
    localparam int LANE_AW      = $clog2(LANE_DEPTH);
    localparam int WR_LANES     = DATA_WIDTH_A / LANE_W;
    localparam int RD_LANES     = DATA_WIDTH_B / LANE_W;

    generate
        if (STORAGE_BITS != storage_bits(ADDRESS_DEPTH_B, DATA_WIDTH_B)
            || !is_pow2(ADDRESS_DEPTH_A) || !is_pow2(ADDRESS_DEPTH_B)
            || !is_pow2(ratio(DATA_WIDTH_A, DATA_WIDTH_B))
            || (ratio(DATA_WIDTH_A, DATA_WIDTH_B) * LANE_W != WIDE_W)) begin : g_bad_cfg
            $error("sdpb_sim: port A and port B geometries are incompatible");
        end
    endgenerate

    logic [LANE_W-1:0]       mem_q [LANE_DEPTH];
    logic                    wr_en;
    logic [LANE_AW-1:0]      wr_idx  [WR_LANES];
    logic [LANE_W-1:0]       wr_lane [WR_LANES];
    logic [DATA_WIDTH_B-1:0] rd_word;
    logic [DATA_WIDTH_B-1:0] rd_q;

    // A wide write spreads over consecutive lanes, little-endian.
    always_comb begin
        wr_en = cea && !reseta;
        for (int r = 0; r < WR_LANES; r++) begin
            wr_idx[r]  = LANE_AW'(int'(ada) * WR_LANES + r);
            wr_lane[r] = din[r*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < RD_LANES; r++) begin
            rd_word[r*LANE_W +: LANE_W] = mem_q[LANE_AW'(int'(adb) * RD_LANES + r)];
        end
    end

    // Storage is deliberately not reset; the read register samples the old
    // contents on a same-edge collision, giving read-first behaviour.
    always_ff @(posedge clka) begin
        if (wr_en) begin
            for (int r = 0; r < WR_LANES; r++) begin
                mem_q[wr_idx[r]] <= wr_lane[r];
            end
        end
    end

    sdpb_out_reg #(.WIDTH(DATA_WIDTH_B)) u_rd_reg (
        .clk (clka),
        .rst (reseta),
        .en  (ceb),
        .d   (rd_word),
        .q   (rd_q)
    );

    generate
        if (READ_MODE == int'(RD_PIPELINE)) begin : g_pipe
            sdpb_out_reg #(.WIDTH(DATA_WIDTH_B)) u_pipe_reg (
                .clk (clka),
                .rst (reseta),
                .en  (oce),
                .d   (rd_q),
                .q   (dout)
            );
        end else begin : g_bypass
            logic unused_oce;
            assign unused_oce = oce;
            assign dout       = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdpb_sim.sv
// Bench for sdpb_sim: bypass, pipeline and inverse-ratio instances against
// a lane-level behavioural memory model.
module tb_sdpb_sim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reseta, cea, ceb, oce;
    logic [2:0]  ada;
    logic [31:0] din;
    logic [3:0]  adb;
    logic [15:0] dout0, dout1;

    logic        cea2, ceb2;
    logic [3:0]  ada2;
    logic [15:0] din2;
    logic [2:0]  adb2;
    logic [31:0] dout2;

    sdpb_sim #(.READ_MODE(0)) u_dut0 (
        .clka(clk), .reseta(reseta), .cea(cea), .ada(ada), .din(din),
        .ceb(ceb), .oce(oce), .adb(adb), .dout(dout0)
    );

    sdpb_sim #(.READ_MODE(1)) u_dut1 (
        .clka(clk), .reseta(reseta), .cea(cea), .ada(ada), .din(din),
        .ceb(ceb), .oce(oce), .adb(adb), .dout(dout1)
    );

    sdpb_sim #(
        .ADDRESS_DEPTH_A(16), .DATA_WIDTH_A(16),
        .ADDRESS_DEPTH_B(8),  .DATA_WIDTH_B(32), .READ_MODE(0)
    ) u_dut2 (
        .clka(clk), .reseta(reseta), .cea(cea2), .ada(ada2), .din(din2),
        .ceb(ceb2), .oce(oce), .adb(adb2), .dout(dout2)
    );

    // Model storage kept as 16-bit words for both geometries.
    logic [15:0] mem_b [16];
    logic [15:0] mem_c [16];
    logic [15:0] exp_rd, exp_pipe;
    logic [31:0] exp_rd2;
    int checks = 0;
    int errors = 0;

    task automatic step();
        logic [15:0] nrd, npipe;
        logic [31:0] nrd2;
        nrd   = exp_rd;
        npipe = exp_pipe;
        nrd2  = exp_rd2;
        if (reseta) begin
            nrd   = '0;
            npipe = '0;
            nrd2  = '0;
        end else begin
            if (ceb)  nrd   = mem_b[int'(adb)];
            if (oce)  npipe = exp_rd;
            if (ceb2) nrd2  = {mem_c[2*int'(adb2)+1], mem_c[2*int'(adb2)]};
            if (cea) begin
                mem_b[2*int'(ada)]   = din[15:0];
                mem_b[2*int'(ada)+1] = din[31:16];
            end
            if (cea2) mem_c[int'(ada2)] = din2;
        end
        @(posedge clk);
        #1;
        exp_rd   = nrd;
        exp_pipe = npipe;
        exp_rd2  = nrd2;
    endtask

    task automatic test_reset();
        reseta = 1'b1;
        repeat (3) step();
        checks++;
        if (dout0 !== 16'h0) begin errors++; $display("FAIL reset_dout0 got %h want 0000", dout0); end
        checks++;
        if (dout1 !== 16'h0) begin errors++; $display("FAIL reset_dout1 got %h want 0000", dout1); end
        checks++;
        if (dout2 !== 32'h0) begin errors++; $display("FAIL reset_dout2 got %h want 00000000", dout2); end
        reseta = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] word;
        logic [15:0] want;
        for (int i = 0; i < 16; i++) begin
            cea  = (i < 8);
            ada  = 3'(i);
            din  = 32'hDEADBEEF ^ 32'(i);
            cea2 = 1'b1;
            ada2 = 4'(i);
            din2 = 16'($urandom);
            step();
        end
        cea  = 1'b0;
        cea2 = 1'b0;
        ceb  = 1'b1;
        ceb2 = 1'b1;
        oce  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            adb  = 4'(k);
            adb2 = 3'(k);
            step();
            word = 32'hDEADBEEF ^ 32'(k / 2);
            want = (k % 2 == 1) ? word[31:16] : word[15:0];
            checks++;
            if (dout0 !== want) begin errors++; $display("FAIL fill_read adb=%0d got %h want %h", k, dout0, want); end
            checks++;
            if (dout1 !== exp_pipe) begin errors++; $display("FAIL fill_pipe adb=%0d got %h want %h", k, dout1, exp_pipe); end
            checks++;
            if (dout2 !== exp_rd2) begin errors++; $display("FAIL fill_inv adb=%0d got %h want %h", k, dout2, exp_rd2); end
            if (k == 0) begin
                checks++;
                if (dout0 !== 16'hBEEF) begin errors++; $display("FAIL fill_adb0 got %h want beef", dout0); end
            end
            if (k == 3) begin
                checks++;
                if (dout0 !== 16'hDEAD) begin errors++; $display("FAIL fill_adb3 got %h want dead", dout0); end
            end
        end
        ceb2 = 1'b0;
    endtask

    task automatic test_ceb_hold();
        ceb = 1'b1;
        adb = 4'd5;
        step();
        checks++;
        if (dout0 !== 16'hDEAD) begin errors++; $display("FAIL hold_first got %h want dead", dout0); end
        ceb = 1'b0;
        adb = 4'd0;
        repeat (3) step();
        checks++;
        if (dout0 !== 16'hDEAD) begin errors++; $display("FAIL hold_ceb0 got %h want dead", dout0); end
    endtask

    task automatic test_reset_write();
        reseta = 1'b1;
        cea    = 1'b1;
        din    = 32'h12345678;
        ada    = 3'd0;
        ceb    = 1'b1;
        adb    = 4'd0;
        repeat (2) step();
        checks++;
        if (dout0 !== 16'h0) begin errors++; $display("FAIL rstwr_dout0 got %h want 0000", dout0); end
        checks++;
        if (dout1 !== 16'h0) begin errors++; $display("FAIL rstwr_dout1 got %h want 0000", dout1); end
        reseta = 1'b0;
        cea    = 1'b0;
        step();
        checks++;
        if (dout0 !== 16'hBEEF) begin errors++; $display("FAIL rstwr_kept got %h want beef", dout0); end
        adb = 4'd1;
        step();
        checks++;
        if (dout0 !== 16'hDEAD) begin errors++; $display("FAIL rstwr_kept_hi got %h want dead", dout0); end
    endtask

    task automatic test_collision();
        cea = 1'b1;
        ada = 3'd1;
        din = 32'h11112222;
        ceb = 1'b0;
        step();
        din = 32'hAAAABBBB;
        ceb = 1'b1;
        adb = 4'd2;
        step();
        checks++;
        if (dout0 !== 16'h2222) begin errors++; $display("FAIL collide_old got %h want 2222", dout0); end
        cea = 1'b0;
        step();
        checks++;
        if (dout0 !== 16'hBBBB) begin errors++; $display("FAIL collide_new got %h want bbbb", dout0); end
    endtask

    task automatic test_pipeline();
        oce = 1'b1;
        ceb = 1'b1;
        adb = 4'd3;
        step();
        checks++;
        if (dout0 !== 16'hAAAA) begin errors++; $display("FAIL pipe_bypass got %h want aaaa", dout0); end
        checks++;
        if (dout1 !== exp_pipe) begin errors++; $display("FAIL pipe_lag got %h want %h", dout1, exp_pipe); end
        ceb = 1'b0;
        step();
        checks++;
        if (dout1 !== 16'hAAAA) begin errors++; $display("FAIL pipe_valid got %h want aaaa", dout1); end
        ceb = 1'b1;
        adb = 4'd2;
        oce = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (dout1 !== 16'hAAAA) begin errors++; $display("FAIL pipe_oce_hold got %h want aaaa", dout1); end
        end
        checks++;
        if (dout0 !== 16'hBBBB) begin errors++; $display("FAIL pipe_oce_ignored got %h want bbbb", dout0); end
        oce = 1'b1;
        step();
        checks++;
        if (dout1 !== 16'hBBBB) begin errors++; $display("FAIL pipe_oce_resume got %h want bbbb", dout1); end
    endtask

    task automatic test_inverse();
        cea2 = 1'b1;
        ada2 = 4'd0;
        din2 = 16'h1111;
        step();
        ada2 = 4'd1;
        din2 = 16'h2222;
        step();
        cea2 = 1'b0;
        ceb2 = 1'b1;
        adb2 = 3'd0;
        step();
        checks++;
        if (dout2 !== 32'h22221111) begin errors++; $display("FAIL inverse got %h want 22221111", dout2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            reseta = ($urandom_range(0, 15) == 0);
            cea    = 1'($urandom_range(0, 1));
            ada    = 3'($urandom);
            din    = $urandom;
            ceb    = 1'($urandom_range(0, 1));
            oce    = 1'($urandom_range(0, 1));
            adb    = 4'($urandom);
            cea2   = 1'($urandom_range(0, 1));
            ada2   = 4'($urandom);
            din2   = 16'($urandom);
            ceb2   = 1'($urandom_range(0, 1));
            adb2   = 3'($urandom);
            step();
            checks++;
            if (dout0 !== exp_rd) begin errors++; $display("FAIL rand_bypass n=%0d got %h want %h", n, dout0, exp_rd); end
            checks++;
            if (dout1 !== exp_pipe) begin errors++; $display("FAIL rand_pipe n=%0d got %h want %h", n, dout1, exp_pipe); end
            checks++;
            if (dout2 !== exp_rd2) begin errors++; $display("FAIL rand_inv n=%0d got %h want %h", n, dout2, exp_rd2); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_b[i] = '0;
            mem_c[i] = '0;
        end
        exp_rd   = '0;
        exp_pipe = '0;
        exp_rd2  = '0;
        reseta = 1'b1;
        cea    = 1'b0;
        ada    = '0;
        din    = '0;
        ceb    = 1'b0;
        oce    = 1'b0;
        adb    = '0;
        cea2   = 1'b0;
        ada2   = '0;
        din2   = '0;
        ceb2   = 1'b0;
        adb2   = '0;

        test_reset();
        test_fill();
        test_ceb_hold();
        test_reset_write();
        test_collision();
        test_pipeline();
        test_inverse();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before the test sequence completed");
        $fatal(1, "timeout");
    end

endmodule
